sdfm_regmap_nch: RTL and testbench

Parametrised register map for the sigma-delta filter module (SDFM), a successor to the fixed two-channel map. It supports NCH channels and configurable decimation/data widths, and is fully synchronous to SYSCLK. It has split read/write data buses with a registered read and an ACK strobe. Per-channel data-ready and overflow status flags, write-1-to-clear semantics and read-side-effect clearing are added. It sits between the host bus and the per-channel filter/comparator datapaths.

---
 rtl/sdfm_regmap_nch_if.sv | 13 +
 rtl/sdfm_regmap_nch.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sdfm_regmap_nch.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdfm_regmap_nch_if.sv
// Host bus for the SDFM register map: strobed byte-addressed access, split read/write
// data, registered read data with a one-cycle ACK.
interface sdfm_regmap_nch_if;
  logic        WR;
  logic        RD;
  logic [15:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        ACK;

  modport master (output WR, RD, ADDR, WDATA, input RDATA, ACK);
  modport slave  (input WR, RD, ADDR, WDATA, output RDATA, ACK);
endinterface

// File: rtl/sdfm_regmap_nch.sv
// NCH-channel SDFM register map: CTL/STAT/IEN plus per-channel DFPARM/CPARM/FDATA.
// Optional macro SDFM_IRQ_EN enables the IEN register and the registered irq output.
module sdfm_regmap_nch #(
  parameter int         NCH           = 2,
  parameter int         DEC_W         = 8,
  parameter int         DATA_W        = 32,
  parameter logic [7:0] ADDR_DEVICE_H = 8'h07
) (
  input  logic                    SYSCLK,
  input  logic                    SYSRSTn,
  sdfm_regmap_nch_if.slave        bus,
  input  logic [NCH*DATA_W-1:0]   filt_data_out,
  input  logic [NCH-1:0]          filt_data_update,
  output logic                    reg_rsten,
  output logic                    reg_clken,
  output logic [NCH*DEC_W-1:0]    reg_filtdec,
  output logic [NCH*2-1:0]        reg_filtmode,
  output logic [NCH*4-1:0]        reg_filtdiv,
  output logic [NCH-1:0]          reg_filten,
  output logic [NCH-1:0]          reg_filtask,
  output logic [NCH*2-1:0]        reg_filtst,
  output logic [NCH*5-1:0]        reg_filtsh,
  output logic [NCH*DEC_W-1:0]    reg_compdec,
  output logic [NCH*2-1:0]        reg_compmode,
  output logic [NCH*4-1:0]        reg_compdiv,
  output logic [NCH-1:0]          reg_compen,
  output logic [NCH-1:0]          reg_comphclrflg,
  output logic [NCH-1:0]          reg_complen,
  output logic [NCH-1:0]          reg_comphen,
  output logic [NCH*2-1:0]        reg_compst,
  output logic                    irq
);

  logic                         ctl_rsten_r, ctl_clken_r;
  logic [NCH-1:0][DEC_W-1:0]    filtdec_r, compdec_r;
  logic [NCH-1:0][1:0]          filtmode_r, filtst_r, compmode_r, compst_r;
  logic [NCH-1:0][3:0]          filtdiv_r, compdiv_r;
  logic [NCH-1:0][4:0]          filtsh_r;
  logic [NCH-1:0]               filten_r, filtask_r;
  logic [NCH-1:0]               compen_r, comphclrflg_r, complen_r, comphen_r;
  logic [NCH-1:0][DATA_W-1:0]   fdata_r;
  logic [NCH-1:0]               drdy_r, ovf_r;
  logic [31:0]                  rdata_r;
  logic                         ack_r;

  logic                         sel_s, wr_acc_s, rd_acc_s, w1c_stat_s;
  logic [7:0]                   off_s;
  logic [NCH-1:0]               hit_dfp_s, hit_cp_s, hit_fd_s;
  logic [NCH-1:0]               drdy_clr_s, ovf_clr_s, ovf_set_s;
  logic [31:0]                  stat_s, ien_s, chan_rd_s, rd_mux_s;
  logic                         unused_wdata_s;

  function automatic logic [31:0] dfp_img(input logic [DEC_W-1:0] dec, input logic [1:0] mode,
                                          input logic [3:0] div, input logic fen, input logic aen,
                                          input logic [1:0] st, input logic [4:0] sh);
    logic [31:0] img;
    img = 32'h0;
    img[DEC_W-1:0] = dec;
    img[13:12]     = mode;
    img[19:16]     = div;
    img[20]        = fen;
    img[21]        = aen;
    img[23:22]     = st;
    img[28:24]     = sh;
    return img;
  endfunction

  function automatic logic [31:0] cp_img(input logic [DEC_W-1:0] dec, input logic [1:0] mode,
                                         input logic [3:0] div, input logic cen, input logic hclr,
                                         input logic len, input logic hen, input logic [1:0] st);
    logic [31:0] img;
    img = 32'h0;
    img[DEC_W-1:0] = dec;
    img[13:12]     = mode;
    img[19:16]     = div;
    img[20]        = cen;
    img[21]        = hclr;
    img[22]        = len;
    img[23]        = hen;
    img[25:24]     = st;
    return img;
  endfunction

  function automatic logic [31:0] sext(input logic [DATA_W-1:0] d);
    return {{(33-DATA_W){d[DATA_W-1]}}, d[DATA_W-2:0]};
  endfunction

  // A simultaneous write wins over a read: only one access, one ACK.
  assign sel_s          = (bus.ADDR[15:8] == ADDR_DEVICE_H) && (bus.WR || bus.RD);
  assign wr_acc_s       = sel_s && bus.WR;
  assign rd_acc_s       = sel_s && bus.RD && !bus.WR;
  assign off_s          = bus.ADDR[7:0];
  assign w1c_stat_s     = wr_acc_s && (off_s == 8'h04);
  assign unused_wdata_s = ^bus.WDATA;

  // Per-channel register decode.
  always_comb begin
    hit_dfp_s = '0;
    hit_cp_s  = '0;
    hit_fd_s  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      hit_dfp_s[ch] = (off_s[7:4] == 4'(ch + 1)) && (off_s[3:0] == 4'h0);
      hit_cp_s[ch]  = (off_s[7:4] == 4'(ch + 1)) && (off_s[3:0] == 4'h4);
      hit_fd_s[ch]  = (off_s[7:4] == 4'(ch + 1)) && (off_s[3:0] == 4'h8);
    end
  end

  // Set beats clear; an update that coincides with the clear is fresh data, not an overflow.
  assign drdy_clr_s = ({NCH{rd_acc_s}} & hit_fd_s) | ({NCH{w1c_stat_s}} & bus.WDATA[NCH-1:0]);
  assign ovf_clr_s  = {NCH{w1c_stat_s}} & bus.WDATA[8 +: NCH];
  assign ovf_set_s  = filt_data_update & drdy_r & ~drdy_clr_s;

  // STAT image.
  always_comb begin
    stat_s             = 32'h0;
    stat_s[NCH-1:0]    = drdy_r;
    stat_s[8 +: NCH]   = ovf_r;
  end

  // Read data multiplexer; unmapped offsets read as zero.
  always_comb begin
    chan_rd_s = 32'h0;
    for (int ch = 0; ch < NCH; ch++) begin
      chan_rd_s = chan_rd_s
                | ({32{hit_dfp_s[ch]}} & dfp_img(filtdec_r[ch], filtmode_r[ch], filtdiv_r[ch],
                                                 filten_r[ch], filtask_r[ch], filtst_r[ch], filtsh_r[ch]))
                | ({32{hit_cp_s[ch]}}  & cp_img(compdec_r[ch], compmode_r[ch], compdiv_r[ch], compen_r[ch],
                                                comphclrflg_r[ch], complen_r[ch], comphen_r[ch], compst_r[ch]))
                | ({32{hit_fd_s[ch]}}  & sext(fdata_r[ch]));
    end
    case (off_s)
      8'h00:   rd_mux_s = {30'h0, ctl_clken_r, ctl_rsten_r};
      8'h04:   rd_mux_s = stat_s;
      8'h08:   rd_mux_s = ien_s;
      default: rd_mux_s = chan_rd_s;
    endcase
  end

  // Configuration register writes.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      ctl_rsten_r   <= 1'b0;
      ctl_clken_r   <= 1'b0;
      filtdec_r     <= '0;
      filtmode_r    <= '0;
      filtdiv_r     <= '0;
      filten_r      <= '0;
      filtask_r     <= '0;
      filtst_r      <= '0;
      filtsh_r      <= '0;
      compdec_r     <= '0;
      compmode_r    <= '0;
      compdiv_r     <= '0;
      compen_r      <= '0;
      comphclrflg_r <= '0;
      complen_r     <= '0;
      comphen_r     <= '0;
      compst_r      <= '0;
    end else begin
      if (wr_acc_s && (off_s == 8'h00)) begin
        ctl_rsten_r <= bus.WDATA[0];
        ctl_clken_r <= bus.WDATA[1];
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (wr_acc_s && hit_dfp_s[ch]) begin
          filtdec_r[ch]  <= bus.WDATA[DEC_W-1:0];
          filtmode_r[ch] <= bus.WDATA[13:12];
          filtdiv_r[ch]  <= bus.WDATA[19:16];
          filten_r[ch]   <= bus.WDATA[20];
          filtask_r[ch]  <= bus.WDATA[21];
          filtst_r[ch]   <= bus.WDATA[23:22];
          filtsh_r[ch]   <= bus.WDATA[28:24];
        end
        if (wr_acc_s && hit_cp_s[ch]) begin
          compdec_r[ch]     <= bus.WDATA[DEC_W-1:0];
          compmode_r[ch]    <= bus.WDATA[13:12];
          compdiv_r[ch]     <= bus.WDATA[19:16];
          compen_r[ch]      <= bus.WDATA[20];
          comphclrflg_r[ch] <= bus.WDATA[21];
          complen_r[ch]     <= bus.WDATA[22];
          comphen_r[ch]     <= bus.WDATA[23];
          compst_r[ch]      <= bus.WDATA[25:24];
        end
      end
    end
  end

  // Filter result capture and data-ready / overflow flags.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      fdata_r <= '0;
      drdy_r  <= '0;
      ovf_r   <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (filt_data_update[ch]) begin
          fdata_r[ch] <= filt_data_out[ch*DATA_W +: DATA_W];
        end
      end
      drdy_r <= filt_data_update | (drdy_r & ~drdy_clr_s);
      ovf_r  <= ovf_set_s | (ovf_r & ~ovf_clr_s);
    end
  end

  // Registered read data and acknowledge.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      rdata_r <= 32'h0;
      ack_r   <= 1'b0;
    end else begin
      rdata_r <= rd_acc_s ? rd_mux_s : 32'h0;
      ack_r   <= sel_s;
    end
  end

`ifdef SDFM_IRQ_EN
  logic [NCH-1:0] ien_drdy_r, ien_ovf_r;
  logic           irq_r;

  always_comb begin
    ien_s           = 32'h0;
    ien_s[NCH-1:0]  = ien_drdy_r;
    ien_s[8 +: NCH] = ien_ovf_r;
  end

  // Interrupt enable register and registered interrupt request.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      ien_drdy_r <= '0;
      ien_ovf_r  <= '0;
      irq_r      <= 1'b0;
    end else begin
      if (wr_acc_s && (off_s == 8'h08)) begin
        ien_drdy_r <= bus.WDATA[NCH-1:0];
        ien_ovf_r  <= bus.WDATA[8 +: NCH];
      end
      irq_r <= |((drdy_r & ien_drdy_r) | (ovf_r & ien_ovf_r));
    end
  end

  assign irq = irq_r;
`else
  assign ien_s = 32'h0;
  assign irq   = 1'b0;
`endif

  assign bus.RDATA       = rdata_r;
  assign bus.ACK         = ack_r;
  assign reg_rsten       = ctl_rsten_r;
  assign reg_clken       = ctl_clken_r;
  assign reg_filtdec     = filtdec_r;
  assign reg_filtmode    = filtmode_r;
  assign reg_filtdiv     = filtdiv_r;
  assign reg_filten      = filten_r;
  assign reg_filtask     = filtask_r;
  assign reg_filtst      = filtst_r;
  assign reg_filtsh      = filtsh_r;
  assign reg_compdec     = compdec_r;
  assign reg_compmode    = compmode_r;
  assign reg_compdiv     = compdiv_r;
  assign reg_compen      = compen_r;
  assign reg_comphclrflg = comphclrflg_r;
  assign reg_complen     = complen_r;
  assign reg_comphen     = comphen_r;
  assign reg_compst      = compst_r;

endmodule

// File: tb/tb_sdfm_regmap_nch.sv
// Directed bench for sdfm_regmap_nch (NCH=4, DEC_W=10, DATA_W=24): a register-image model
// checked against the DUT every cycle, plus hand-computed expectations.
`timescale 1ns/1ps
module tb_sdfm_regmap_nch;
  localparam int         NCH    = 4;
  localparam int         DEC_W  = 10;
  localparam int         DATA_W = 24;
  localparam logic [7:0] DEV    = 8'h07;
  localparam logic [31:0] DEC_M = 32'h0000_03FF;
  localparam logic [31:0] CTL_M = 32'h0000_0003;
  localparam logic [31:0] DFP_M = 32'h1FFF_3000 | DEC_M;
  localparam logic [31:0] CP_M  = 32'h03FF_3000 | DEC_M;
`ifdef SDFM_IRQ_EN
  localparam logic [31:0] IEN_M = 32'h0000_0F0F;
`else
  localparam logic [31:0] IEN_M = 32'h0000_0000;
`endif

  logic SYSCLK = 1'b0;
  logic SYSRSTn;
  sdfm_regmap_nch_if bus();
  logic [NCH*DATA_W-1:0] filt_data_out;
  logic [NCH-1:0]        filt_data_update;
  logic                  reg_rsten, reg_clken, irq;
  logic [NCH*DEC_W-1:0]  reg_filtdec, reg_compdec;
  logic [NCH*2-1:0]      reg_filtmode, reg_filtst, reg_compmode, reg_compst;
  logic [NCH*4-1:0]      reg_filtdiv, reg_compdiv;
  logic [NCH*5-1:0]      reg_filtsh;
  logic [NCH-1:0]        reg_filten, reg_filtask, reg_compen, reg_comphclrflg, reg_complen, reg_comphen;

  sdfm_regmap_nch #(.NCH(NCH), .DEC_W(DEC_W), .DATA_W(DATA_W), .ADDR_DEVICE_H(DEV)) dut (
    .SYSCLK(SYSCLK), .SYSRSTn(SYSRSTn), .bus(bus),
    .filt_data_out(filt_data_out), .filt_data_update(filt_data_update),
    .reg_rsten(reg_rsten), .reg_clken(reg_clken),
    .reg_filtdec(reg_filtdec), .reg_filtmode(reg_filtmode), .reg_filtdiv(reg_filtdiv),
    .reg_filten(reg_filten), .reg_filtask(reg_filtask), .reg_filtst(reg_filtst), .reg_filtsh(reg_filtsh),
    .reg_compdec(reg_compdec), .reg_compmode(reg_compmode), .reg_compdiv(reg_compdiv),
    .reg_compen(reg_compen), .reg_comphclrflg(reg_comphclrflg), .reg_complen(reg_complen),
    .reg_comphen(reg_comphen), .reg_compst(reg_compst), .irq(irq)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Model: register images as the host sees them, plus the capture/flag state.
  logic [31:0]       m_ctl, m_ien, m_rdata;
  logic [31:0]       m_dfp [NCH];
  logic [31:0]       m_cp  [NCH];
  logic [DATA_W-1:0] m_fd  [NCH];
  logic [NCH-1:0]    m_drdy, m_ovf;
  logic              m_ack, m_irq;
  int                n_cmp = 0;
  int                n_err = 0;
  bit                chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ctl = 32'h0; m_ien = 32'h0; m_rdata = 32'h0; m_ack = 1'b0; m_irq = 1'b0;
    m_drdy = '0; m_ovf = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_dfp[ch] = 32'h0; m_cp[ch] = 32'h0; m_fd[ch] = '0;
    end
  endtask

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s = 32'h0;
    for (int ch = 0; ch < NCH; ch++) begin
      s[ch] = m_drdy[ch];
      s[8 + ch] = m_ovf[ch];
    end
    return s;
  endfunction

  function automatic logic [31:0] sx(input logic [DATA_W-1:0] d);
    int v;
    v = int'(d);
    if (d[DATA_W-1]) v = v - (1 << DATA_W);
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    int ch;
    logic [31:0] v;
    v = 32'h0;
    if (off == 8'h00) v = m_ctl;
    else if (off == 8'h04) v = m_stat();
    else if (off == 8'h08) v = m_ien;
    else if (off >= 8'h10 && int'(off[7:4]) <= NCH) begin
      ch = int'(off[7:4]) - 1;
      if (off[3:0] == 4'h0) v = m_dfp[ch];
      else if (off[3:0] == 4'h4) v = m_cp[ch];
      else if (off[3:0] == 4'h8) v = sx(m_fd[ch]);
    end
    return v;
  endfunction

  task automatic m_step(input logic wr, input logic rd, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [NCH-1:0] upd, input logic [NCH*DATA_W-1:0] fin);
    logic sel, rd_ok;
    logic [7:0] off;
    logic [NCH-1:0] clr, oclr;
    logic [31:0] rv;
    logic irq_n;
    sel   = (addr[15:8] == DEV) && (wr || rd);
    rd_ok = sel && rd && !wr;
    off   = addr[7:0];
    rv    = m_read(off);
    irq_n = |(m_stat() & m_ien);
    clr = '0; oclr = '0;
    if (rd_ok && off >= 8'h10 && off[3:0] == 4'h8 && int'(off[7:4]) <= NCH)
      clr[int'(off[7:4]) - 1] = 1'b1;
    if (sel && wr && off == 8'h04) begin
      clr  = clr | wd[NCH-1:0];
      oclr = wd[8 +: NCH];
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (upd[ch]) begin
        if (m_drdy[ch] && !clr[ch]) m_ovf[ch] = 1'b1;
        else if (oclr[ch]) m_ovf[ch] = 1'b0;
        m_drdy[ch] = 1'b1;
        m_fd[ch] = fin[ch*DATA_W +: DATA_W];
      end else begin
        if (clr[ch]) m_drdy[ch] = 1'b0;
        if (oclr[ch]) m_ovf[ch] = 1'b0;
      end
    end
    if (sel && wr) begin
      if (off == 8'h00) m_ctl = wd & CTL_M;
      else if (off == 8'h08) m_ien = wd & IEN_M;
      else if (off >= 8'h10 && int'(off[7:4]) <= NCH) begin
        if (off[3:0] == 4'h0) m_dfp[int'(off[7:4]) - 1] = wd & DFP_M;
        else if (off[3:0] == 4'h4) m_cp[int'(off[7:4]) - 1] = wd & CP_M;
      end
    end
    m_irq   = irq_n;
    m_rdata = rd_ok ? rv : 32'h0;
    m_ack   = sel;
  endtask

  // Expected output vectors extracted from the register images by field position.
  logic [NCH*DEC_W-1:0] e_fdec, e_cdec;
  logic [NCH*2-1:0]     e_fmode, e_fst, e_cmode, e_cst;
  logic [NCH*4-1:0]     e_fdiv, e_cdiv;
  logic [NCH*5-1:0]     e_fsh;
  logic [NCH-1:0]       e_fen, e_fask, e_cen, e_chclr, e_clen, e_chen;
  always_comb begin
    e_fdec = '0; e_cdec = '0; e_fmode = '0; e_fst = '0; e_cmode = '0; e_cst = '0;
    e_fdiv = '0; e_cdiv = '0; e_fsh = '0; e_fen = '0; e_fask = '0;
    e_cen = '0; e_chclr = '0; e_clen = '0; e_chen = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      e_fdec[ch*DEC_W +: DEC_W] = m_dfp[ch][DEC_W-1:0];
      e_fmode[ch*2 +: 2] = m_dfp[ch][13:12];
      e_fdiv[ch*4 +: 4]  = m_dfp[ch][19:16];
      e_fen[ch]          = m_dfp[ch][20];
      e_fask[ch]         = m_dfp[ch][21];
      e_fst[ch*2 +: 2]   = m_dfp[ch][23:22];
      e_fsh[ch*5 +: 5]   = m_dfp[ch][28:24];
      e_cdec[ch*DEC_W +: DEC_W] = m_cp[ch][DEC_W-1:0];
      e_cmode[ch*2 +: 2] = m_cp[ch][13:12];
      e_cdiv[ch*4 +: 4]  = m_cp[ch][19:16];
      e_cen[ch]          = m_cp[ch][20];
      e_chclr[ch]        = m_cp[ch][21];
      e_clen[ch]         = m_cp[ch][22];
      e_chen[ch]         = m_cp[ch][23];
      e_cst[ch*2 +: 2]   = m_cp[ch][25:24];
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge SYSCLK) begin
    if (chk_en) begin
      chk("ack",      64'(bus.ACK),         64'(m_ack));
      chk("rdata",    64'(bus.RDATA),       64'(m_rdata));
      chk("irq",      64'(irq),             64'(m_irq));
      chk("rsten",    64'(reg_rsten),       64'(m_ctl[0]));
      chk("clken",    64'(reg_clken),       64'(m_ctl[1]));
      chk("filtdec",  64'(reg_filtdec),     64'(e_fdec));
      chk("filtmode", 64'(reg_filtmode),    64'(e_fmode));
      chk("filtdiv",  64'(reg_filtdiv),     64'(e_fdiv));
      chk("filten",   64'(reg_filten),      64'(e_fen));
      chk("filtask",  64'(reg_filtask),     64'(e_fask));
      chk("filtst",   64'(reg_filtst),      64'(e_fst));
      chk("filtsh",   64'(reg_filtsh),      64'(e_fsh));
      chk("compdec",  64'(reg_compdec),     64'(e_cdec));
      chk("compmode", 64'(reg_compmode),    64'(e_cmode));
      chk("compdiv",  64'(reg_compdiv),     64'(e_cdiv));
      chk("compen",   64'(reg_compen),      64'(e_cen));
      chk("comphclr", 64'(reg_comphclrflg), 64'(e_chclr));
      chk("complen",  64'(reg_complen),     64'(e_clen));
      chk("comphen",  64'(reg_comphen),     64'(e_chen));
      chk("compst",   64'(reg_compst),      64'(e_cst));
    end
  end

  task automatic cyc(input logic wr, input logic rd, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [NCH-1:0] upd, input logic [NCH*DATA_W-1:0] fin);
    bus.WR = wr; bus.RD = rd; bus.ADDR = addr; bus.WDATA = wd;
    filt_data_update = upd; filt_data_out = fin;
    @(posedge SYSCLK);
    if (!SYSRSTn) m_reset();
    else m_step(wr, rd, addr, wd, upd, fin);
    #1;
  endtask

  task automatic do_idle();
    cyc(1'b0, 1'b0, 16'h0000, 32'h0, '0, '0);
  endtask

  task automatic do_wr(input logic [15:0] addr, input logic [31:0] wd);
    cyc(1'b1, 1'b0, addr, wd, '0, '0);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [31:0] exp);
    cyc(1'b0, 1'b1, addr, 32'h0, '0, '0);
    chk(nm, 64'(bus.RDATA), 64'(exp));
    chk({nm, "_ack"}, 64'(bus.ACK), 64'h1);
  endtask

  task automatic do_upd(input int ch, input logic [DATA_W-1:0] val, input logic rd, input logic [15:0] addr);
    logic [NCH*DATA_W-1:0] fin;
    logic [NCH-1:0] u;
    fin = '0; u = '0;
    fin[ch*DATA_W +: DATA_W] = val;
    u[ch] = 1'b1;
    cyc(1'b0, rd, addr, 32'h0, u, fin);
  endtask

  initial begin
    SYSRSTn = 1'b0;
    bus.WR = 1'b0; bus.RD = 1'b0; bus.ADDR = 16'h0; bus.WDATA = 32'h0;
    filt_data_update = '0; filt_data_out = '0;
    m_reset();
    do_idle();
    chk_en = 1'b1;
    do_idle();
    chk("rst_ack", 64'(bus.ACK), 64'h0);
    chk("rst_rdata", 64'(bus.RDATA), 64'h0);
    SYSRSTn = 1'b1;
    do_idle();

    // Reset values and ACK timing; a foreign device address is ignored.
    rd_chk("rd_ctl_rst", 16'h0700, 32'h0);
    rd_chk("rd_stat_rst", 16'h0704, 32'h0);
    rd_chk("rd_dfp0_rst", 16'h0710, 32'h0);
    do_idle();
    chk("rdata_back0", 64'(bus.RDATA), 64'h0);
    chk("ack_back0", 64'(bus.ACK), 64'h0);
    do_wr(16'h0800, 32'hFFFF_FFFF);
    chk("foreign_ack", 64'(bus.ACK), 64'h0);

    // Field placement of DFPARM/CPARM/CTL.
    do_wr(16'h0730, 32'h1F3A_D3FF);
    chk("dfp2_dec", 64'(reg_filtdec[29:20]), 64'h3FF);
    chk("dfp2_mode", 64'(reg_filtmode[5:4]), 64'h1);
    chk("dfp2_div", 64'(reg_filtdiv[11:8]), 64'hA);
    chk("dfp2_fen", 64'(reg_filten[2]), 64'h1);
    chk("dfp2_aen", 64'(reg_filtask[2]), 64'h1);
    chk("dfp2_st", 64'(reg_filtst[5:4]), 64'h0);
    chk("dfp2_sh", 64'(reg_filtsh[14:10]), 64'h1F);
    rd_chk("rd_dfp2", 16'h0730, 32'h1F3A_13FF);
    do_wr(16'h0730, 32'hFFFF_FFFF);
    rd_chk("rd_dfp2_ones", 16'h0730, 32'h1FFF_33FF);
    do_wr(16'h0744, 32'hFFFF_FFFF);
    chk("cp3_st", 64'(reg_compst[7:6]), 64'h3);
    chk("cp3_hen", 64'(reg_comphen[3]), 64'h1);
    rd_chk("rd_cp3", 16'h0744, 32'h03FF_33FF);
    do_wr(16'h0700, 32'hFFFF_FFFF);
    rd_chk("rd_ctl", 16'h0700, 32'h0000_0003);
    rd_chk("rd_ch4_unmapped", 16'h0750, 32'h0);
    rd_chk("rd_0c_unmapped", 16'h070C, 32'h0);
    do_wr(16'h0718, 32'hFFFF_FFFF);
    rd_chk("rd_fd0_ro", 16'h0718, 32'h0);

    // Simultaneous RD and WR: write performed, read returns zero.
    cyc(1'b1, 1'b1, 16'h0700, 32'h0, '0, '0);
    chk("rdwr_ack", 64'(bus.ACK), 64'h1);
    chk("rdwr_rdata", 64'(bus.RDATA), 64'h0);
    do_idle();
    chk("rdwr_rsten", 64'(reg_rsten), 64'h0);

    // Capture with sign extension; read clears DRDY.
    do_upd(1, 24'h80_0001, 1'b0, 16'h0);
    rd_chk("stat_drdy1", 16'h0704, 32'h0000_0002);
    rd_chk("rd_fd1", 16'h0728, 32'hFF80_0001);
    rd_chk("stat_after_fd1", 16'h0704, 32'h0);

    // Overflow, W1C, and read coinciding with a new update.
    do_upd(0, 24'h00_0123, 1'b0, 16'h0);
    do_upd(0, 24'h7F_FFFF, 1'b0, 16'h0);
    rd_chk("stat_ovf0", 16'h0704, 32'h0000_0101);
    do_wr(16'h0704, 32'h0000_0100);
    rd_chk("stat_w1c", 16'h0704, 32'h0000_0001);
    do_upd(0, 24'h00_0055, 1'b1, 16'h0718);
    chk("rd_fd0_coinc", 64'(bus.RDATA), 64'h007F_FFFF);
    rd_chk("stat_coinc", 16'h0704, 32'h0000_0001);
    rd_chk("rd_fd0_new", 16'h0718, 32'h0000_0055);
    rd_chk("stat_clr0", 16'h0704, 32'h0);

    // Held RD on FDATA returns the same data every cycle.
    do_upd(2, 24'h12_3456, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) rd_chk("rd_fd2_held", 16'h0738, 32'h0012_3456);
    rd_chk("stat_held", 16'h0704, 32'h0);

    // Interrupt path.
    do_wr(16'h0704, 32'h0000_0F0F);
    do_wr(16'h0708, 32'h0000_0002);
    do_upd(1, 24'h00_0042, 1'b0, 16'h0);
    chk("irq_pulse_edge", 64'(irq), 64'h0);
    do_idle();
`ifdef SDFM_IRQ_EN
    chk("irq_set", 64'(irq), 64'h1);
    rd_chk("rd_ien", 16'h0708, 32'h0000_0002);
    rd_chk("rd_fd1_irq", 16'h0728, 32'h0000_0042);
    do_idle();
    chk("irq_clr", 64'(irq), 64'h0);
`else
    chk("irq_off", 64'(irq), 64'h0);
    rd_chk("rd_ien", 16'h0708, 32'h0);
    rd_chk("rd_fd1_irq", 16'h0728, 32'h0000_0042);
`endif

    // Asynchronous reset between read acceptance and the ACK cycle's end.
    do_wr(16'h0700, 32'h0000_0003);
    do_upd(3, 24'h00_ABCD, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h0748, 32'h0, '0, '0);
    chk("pre_rst_ack", 64'(bus.ACK), 64'h1);
    #2;
    SYSRSTn = 1'b0;
    bus.RD = 1'b0;
    m_reset();
    #1;
    chk("midrst_ack", 64'(bus.ACK), 64'h0);
    chk("midrst_rdata", 64'(bus.RDATA), 64'h0);
    chk("midrst_rsten", 64'(reg_rsten), 64'h0);
    chk("midrst_filtdec", 64'(reg_filtdec), 64'h0);
    do_idle();
    SYSRSTn = 1'b1;
    do_idle();
    rd_chk("post_rst_stat", 16'h0704, 32'h0);
    rd_chk("post_rst_fd3", 16'h0748, 32'h0);
    rd_chk("post_rst_dfp2", 16'h0730, 32'h0);
    rd_chk("post_rst_ctl", 16'h0700, 32'h0);
    do_idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
